// File: rtl/rsa_mult_arbiter_if.sv
// rsa_mult_arbiter_if
//   Bundles the two requester channels and the shared multiplier channel
//   of rsa_mult_arbiter.
//   Requester N : reqN_valid/reqN_ready handshake with operands reqN_a/reqN_b,
//                 and a one-cycle rspN_valid pulse carrying rspN_c/rspN_err.
//   Multiplier  : m_start pulse with operands m_a/m_b; m_done qualifies m_c.
//   Modports    : slave  - the arbiter's view (serves requests, drives the multiplier)
//                 master - the environment's view (requesters plus multiplier)
interface rsa_mult_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      req0_valid;
    logic                      req1_valid;
    logic [DATA_WIDTH-1:0]     req0_a;
    logic [DATA_WIDTH-1:0]     req0_b;
    logic [DATA_WIDTH-1:0]     req1_a;
    logic [DATA_WIDTH-1:0]     req1_b;
    logic                      req0_ready;
    logic                      req1_ready;

    logic                      rsp0_valid;
    logic                      rsp1_valid;
    logic [2*DATA_WIDTH-1:0]   rsp0_c;
    logic [2*DATA_WIDTH-1:0]   rsp1_c;
    logic                      rsp0_err;
    logic                      rsp1_err;

    logic                      m_start;
    logic [DATA_WIDTH-1:0]     m_a;
    logic [DATA_WIDTH-1:0]     m_b;
    logic                      m_done;
    logic [2*DATA_WIDTH-1:0]   m_c;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp0_c, rsp1_c, rsp0_err, rsp1_err,
        output m_start, m_a, m_b,
        input  m_done, m_c
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp0_c, rsp1_c, rsp0_err, rsp1_err,
        input  m_start, m_a, m_b,
        output m_done, m_c
    );
endinterface

// File: rtl/rsa_mult_arbiter.sv
// rsa_mult_arbiter
//   Round-robin arbiter sharing one shift-add multiplier between two
//   requesters. One operation is in flight at a time:
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE. An operation whose multiplier
//   does not answer within TIMEOUT WAIT cycles returns a zero product with
//   its error flag set.
// Ports
//   arb_clk   : clock, rising edge
//   arb_rst   : asynchronous active-low reset
//   bus       : requester and multiplier channels (rsa_mult_arbiter_if.slave)
//   arb_busy  : high while an operation is in flight (ISSUE/WAIT/RESP)
//   arb_owner : index of the current or most recent grant
//   arb_err   : sticky timeout indicator, cleared only by reset
module rsa_mult_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 40
) (
    input  logic               arb_clk,
    input  logic               arb_rst,
    rsa_mult_arbiter_if.slave  bus,
    output logic               arb_busy,
    output logic               arb_owner,
    output logic               arb_err
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Counter runs 0..TIMEOUT-1 across the WAIT cycles.
    localparam int         CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]              state;
    logic                    last_grant;
    logic                    owner;
    logic                    winner;
    logic                    accept;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [2*DATA_WIDTH-1:0] c0_q;
    logic [2*DATA_WIDTH-1:0] c1_q;
    logic                    err0_q;
    logic                    err1_q;
    logic                    arb_err_q;

    // With both valid the requester not granted last wins; otherwise the
    // single valid one wins (value is irrelevant when neither is valid).
    // The reset term keeps readys low while reset is held.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant;
        end else begin
            winner = ~bus.req0_valid;
        end
        accept = (state == ST_IDLE) && (bus.req0_valid || bus.req1_valid) && arb_rst;
    end

    assign bus.req0_ready = accept && !winner;
    assign bus.req1_ready = accept &&  winner;

    assign bus.m_start    = (state == ST_ISSUE);
    assign bus.m_a        = a_q;
    assign bus.m_b        = b_q;

    assign bus.rsp0_valid = (state == ST_RESP) && !owner;
    assign bus.rsp1_valid = (state == ST_RESP) &&  owner;
    assign bus.rsp0_c     = c0_q;
    assign bus.rsp1_c     = c1_q;
    assign bus.rsp0_err   = err0_q;
    assign bus.rsp1_err   = err1_q;

    assign arb_busy       = (state != ST_IDLE);
    assign arb_owner      = owner;
    assign arb_err        = arb_err_q;

    always_ff @(posedge arb_clk or negedge arb_rst) begin
        if (!arb_rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c0_q       <= '0;
            c1_q       <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            arb_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q        <= winner ? bus.req1_a : bus.req0_a;
                        b_q        <= winner ? bus.req1_b : bus.req0_b;
                        owner      <= winner;
                        last_grant <= winner;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // m_done wins over a coincident timeout.
                    if (bus.m_done) begin
                        if (owner) begin
                            c1_q   <= bus.m_c;
                            err1_q <= 1'b0;
                        end else begin
                            c0_q   <= bus.m_c;
                            err0_q <= 1'b0;
                        end
                        state <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        if (owner) begin
                            c1_q   <= '0;
                            err1_q <= 1'b1;
                        end else begin
                            c0_q   <= '0;
                            err0_q <= 1'b1;
                        end
                        arb_err_q <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_mult_arbiter.sv
// tb_rsa_mult_arbiter
//   Randomized and directed stimulus for rsa_mult_arbiter, checked against a
//   transaction-level reference model (round-robin pointer, product a*b,
//   timeout after TIMEOUT WAIT cycles, sticky error).
module tb_rsa_mult_arbiter;
    localparam int DW = 8;
    localparam int TO = 40;

    logic arb_clk = 1'b0;
    logic arb_rst = 1'b0;
    logic arb_busy;
    logic arb_owner;
    logic arb_err;

    rsa_mult_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    rsa_mult_arbiter #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .arb_clk   (arb_clk),
        .arb_rst   (arb_rst),
        .bus       (bus),
        .arb_busy  (arb_busy),
        .arb_owner (arb_owner),
        .arb_err   (arb_err)
    );

    always #5 arb_clk = ~arb_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic            mdl_last;
    logic            mdl_err;
    logic [2*DW-1:0] mdl_c [2];
    logic            mdl_rerr [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_last    = 1'b1;
        mdl_err     = 1'b0;
        mdl_c[0]    = '0;
        mdl_c[1]    = '0;
        mdl_rerr[0] = 1'b0;
        mdl_rerr[1] = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctl"}, 32'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                                  bus.m_start, arb_busy, arb_err, bus.rsp0_err, bus.rsp1_err}), 32'd0);
        check({tag, "_mab"}, 32'({bus.m_a, bus.m_b}), 32'd0);
        check({tag, "_c0"},  32'(bus.rsp0_c), 32'd0);
        check({tag, "_c1"},  32'(bus.rsp1_c), 32'd0);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_c0"},   32'(bus.rsp0_c), 32'(mdl_c[0]));
        check({tag, "_c1"},   32'(bus.rsp1_c), 32'(mdl_c[1]));
        check({tag, "_errs"}, 32'({bus.rsp0_err, bus.rsp1_err, arb_err}),
                              32'({mdl_rerr[0], mdl_rerr[1], mdl_err}));
    endtask

    // Runs one transaction starting at an IDLE cycle (just after a negedge).
    // lat: WAIT cycle (1-based) on which the multiplier answers; 0 or
    // anything beyond TO means it never answers in time.
    task automatic run_txn(input logic v0, input logic v1,
                           input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                           input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                           input int lat, input logic toggle);
        logic            win;
        logic            ok;
        logic [DW-1:0]   wa;
        logic [DW-1:0]   wb;
        logic [2*DW-1:0] prod;
        int              k_exp;

        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_a = a1; bus.req1_b = b1;
        #1;
        win = (v0 && v1) ? !mdl_last : !v0;
        check("grant_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'({!win, win}));
        wa       = win ? a1 : a0;
        wb       = win ? b1 : b0;
        mdl_last = win;

        @(negedge arb_clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("issue", 32'({arb_busy, bus.m_start, arb_owner, bus.req0_ready, bus.req1_ready, bus.m_a, bus.m_b}),
                       32'({1'b1, 1'b1, win, 1'b0, 1'b0, wa, wb}));

        ok    = (lat >= 1) && (lat <= TO);
        k_exp = ok ? lat + 1 : TO + 1;
        prod  = ok ? (2*DW)'(wa) * (2*DW)'(wb) : '0;

        for (int k = 1; k < k_exp; k++) begin
            @(negedge arb_clk);
            if (toggle) begin
                bus.req0_valid = 1'($urandom);
                bus.req1_valid = 1'($urandom);
            end
            bus.m_done = (k == lat);
            bus.m_c    = (k == lat) ? prod : (2*DW)'($urandom);
            #1;
            check("wait", 32'({arb_busy, bus.m_start, bus.req0_ready, bus.req1_ready,
                               bus.rsp0_valid, bus.rsp1_valid, bus.m_a, bus.m_b}),
                          32'({6'b100000, wa, wb}));
        end

        @(negedge arb_clk);
        bus.m_done     = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        mdl_c[win]     = prod;
        mdl_rerr[win]  = !ok;
        if (!ok) mdl_err = 1'b1;
        #1;
        check("resp_valid", 32'({arb_busy, bus.m_start, bus.rsp1_valid, bus.rsp0_valid}),
                            32'({1'b1, 1'b0, win, !win}));
        check_held("resp");

        @(negedge arb_clk);
        #1;
        check("idle", 32'({arb_busy, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        check_held("hold");
    endtask

    task automatic spurious_done();
        @(negedge arb_clk);
        bus.m_done = 1'b1;
        bus.m_c    = (2*DW)'($urandom);
        #1;
        check("spur_idle", 32'({arb_busy, bus.rsp0_valid, bus.rsp1_valid, bus.m_start}), 32'd0);
        @(negedge arb_clk);
        bus.m_done = 1'b0;
        #1;
        check("spur_after", 32'({arb_busy, bus.rsp0_valid, bus.rsp1_valid, bus.m_start}), 32'd0);
        check_held("spur");
    endtask

    task automatic reset_mid_wait();
        bus.req1_valid = 1'b1;
        bus.req1_a = 8'd7; bus.req1_b = 8'd9;
        @(negedge arb_clk);           // ISSUE
        bus.req1_valid = 1'b0;
        repeat (5) @(negedge arb_clk); // inside WAIT
        #1;
        check("rmw_busy", 32'(arb_busy), 32'd1);
        arb_rst        = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        mdl_reset();
        check_reset_state("rmw_rst");
        @(negedge arb_clk);
        arb_rst        = 1'b1;
        bus.req0_valid = 1'b0;
        bus.m_done     = 1'b1;        // late answer for the dropped operation
        bus.m_c        = 16'd63;
        #1;
        check("rmw_late", 32'({arb_busy, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        @(negedge arb_clk);
        bus.m_done = 1'b0;
        #1;
        check("rmw_after", 32'({arb_busy, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        check_held("rmw");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_a = '0; bus.req1_b = '0;
        bus.m_done = 1'b0;
        bus.m_c    = '0;
        mdl_reset();

        repeat (2) @(negedge arb_clk);
        #1;
        check_reset_state("reset");
        @(negedge arb_clk);
        arb_rst = 1'b1;

        // Tie straight after reset: req0 first, then req1 with 255*255.
        run_txn(1'b1, 1'b1, 8'd3, 8'd4, 8'd255, 8'd255, 3, 1'b0);
        run_txn(1'b0, 1'b1, 8'd0, 8'd0, 8'd255, 8'd255, 5, 1'b0);
        check("rsp1_65025", 32'(bus.rsp1_c), 32'd65025);
        // Repeated ties alternate.
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 8'(i + 1), 8'd2, 8'(i + 10), 8'd3, 2, 1'b0);
        end

        // Single requester, 12*11.
        run_txn(1'b1, 1'b0, 8'd12, 8'd11, 8'd0, 8'd0, 4, 1'b1);
        check("rsp0_132", 32'({bus.rsp0_c, bus.rsp0_err}), 32'({16'd132, 1'b0}));

        // Multiplier never answers, then a normal request.
        run_txn(1'b1, 1'b0, 8'd5, 8'd6, 8'd0, 8'd0, 0, 1'b1);
        run_txn(1'b0, 1'b1, 8'd0, 8'd0, 8'd9, 8'd9, 7, 1'b0);

        // Answer exactly on the timeout cycle.
        run_txn(1'b1, 1'b0, 8'd200, 8'd3, 8'd0, 8'd0, TO, 1'b1);

        spurious_done();
        reset_mid_wait();
        run_txn(1'b1, 1'b1, 8'd8, 8'd8, 8'd2, 8'd2, 6, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int   sel;
            int   lat;
            logic v0;
            logic v1;
            v0  = 1'($urandom);
            v1  = 1'($urandom);
            if (!v0 && !v1) v1 = 1'b1;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      lat = 0;
            else if (sel == 1) lat = TO;
            else if (sel == 2) lat = TO + 1;
            else               lat = int'($urandom_range(1, 12));
            run_txn(v0, v1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    lat, 1'($urandom));
            if (i == 12) spurious_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rsa_mult_arbiter.md
RSA_MULT_ARBITER -- requirements
Module: rsa_mult_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width of the shared shift-add multiplier.
REQ-002 SHALL have parameter TIMEOUT, default 40, maximum number of WAIT cycles before the operation is abandoned.
REQ-003 SHALL have port arb_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port arb_rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each, requester N presents an operand pair.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, DATA_WIDTH each, operands.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 each, request accepted this cycle when valid and ready are both high.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid, output, 1 each, one-cycle result pulse.
REQ-009 SHALL have ports rsp0_c/rsp1_c, output, 2*DATA_WIDTH each, product; rsp0_err/rsp1_err, output, 1 each, timeout flag qualified by rspN_valid.
REQ-010 SHALL have ports m_start (output, 1), m_a and m_b (output, DATA_WIDTH), m_done (input, 1), m_c (input, 2*DATA_WIDTH), multiplier side; m_start and m_done are active-high.
REQ-011 SHALL have ports arb_busy (output, 1), arb_owner (output, 1, index of current or last grant) and arb_err (output, 1, sticky timeout).

Function
REQ-012 SHALL implement a state machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-013 IDLE: SHALL assert reqN_ready combinationally to exactly one valid requester (the winner); with no valid request, both readys are low.
REQ-014 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that requester wins.
REQ-015 On accept, SHALL latch a and b into registers, set arb_owner to the winner and go to ISSUE next cycle.
REQ-016 m_a and m_b SHALL be driven from the latched registers and held stable from ISSUE until the next accept.
REQ-017 ISSUE: SHALL assert m_start for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-018 WAIT: SHALL increment a timeout counter each cycle; on m_done=1, SHALL capture m_c into the owner's result register and go to RESP.
REQ-019 WAIT: if the counter reaches TIMEOUT with m_done low, SHALL set the result to 0, set the owner's err flag and arb_err, then go to RESP.
REQ-020 RESP: SHALL pulse rspN_valid for the owner only, for one cycle, with no back-pressure; then go to IDLE.
REQ-021 rspN_c and rspN_err SHALL hold their last values until the next response to requester N.
REQ-022 arb_busy SHALL be high in ISSUE, WAIT and RESP, and low in IDLE.
REQ-023 m_done outside WAIT SHALL be ignored; m_done coinciding with the timeout cycle SHALL take priority, giving a valid result with err low.
REQ-024 arb_err SHALL be sticky until reset; no new request SHALL be accepted outside IDLE.
REQ-025 reqN_valid dropping without ready SHALL not be an error; the arbiter re-evaluates every IDLE cycle.

Reset
REQ-026 arb_rst low SHALL immediately force IDLE and clear to 0: m_start, m_a, m_b, all readys, rsp valids, results, err flags, arb_busy, arb_err and the counter; the last-grant pointer is set to 1 so req0 wins the first tie.
REQ-027 Reset during ISSUE/WAIT/RESP SHALL drop the operation with no response; m_done arriving after reset release SHALL be ignored.

Verification
REQ-028 req0 a=12, b=11 alone -> req0_ready one cycle, m_start one pulse, m_a=12, m_b=11; on m_done with m_c=132 -> rsp0_valid one cycle, rsp0_c=132, rsp0_err=0.
REQ-029 req0 and req1 valid together after reset -> req0 served first, then req1 (a=255, b=255 -> rsp1_c=65025); repeated ties alternate 0,1,0,1.
REQ-030 Multiplier model never asserts m_done -> after 40 WAIT cycles: rsp valid, c=0, err=1, arb_err=1 and stays high; the next request completes normally with err=0.
REQ-031 arb_rst low mid-WAIT, then a late m_done -> no rsp pulse, all outputs 0, arbiter accepts a new request normally.
REQ-032 m_done on the same cycle the counter reaches TIMEOUT -> result captured, err=0, arb_err unchanged.
REQ-033 Spurious m_done in IDLE, and reqN_valid toggled during WAIT -> ignored; no ready is asserted until IDLE.
